// File: rtl/axis_rate_limit_if.sv
// ----------------------------------------------------------------------------
// axis_rate_limit_if
// AXI4-Stream bundle used by axis_rate_limit for both its input and output side.
//   tdata  : payload, DATA_WIDTH bits
//   tvalid : source has a word
//   tready : sink can take a word
//   tlast  : final word of a frame
//   tuser  : user/error flag, carried alongside tdata
// master modport drives the payload and valid; slave modport drives ready.
// ----------------------------------------------------------------------------
interface axis_rate_limit_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic                  tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/axis_rate_limit.sv
// ----------------------------------------------------------------------------
// axis_rate_limit
// Paces an AXI4-Stream to an average of rate_num/rate_denom words per cycle
// using a saturating credit accumulator and a single output register.
//
// Ports:
//   clk         : single clock, rising edge
//   rst_n       : asynchronous active-low reset
//   input_axis  : upstream stream (slave side; tready is generated here)
//   output_axis : registered downstream stream (master side)
//   rate_num    : credit returned per cycle
//   rate_denom  : cost charged per accepted word
//   pause       : current throttle state, status only
//
// Optional feature: define AXIS_RATE_LIMIT_FRAME_EN to defer throttling to
// frame boundaries, so a started frame streams without rate-induced gaps.
// ----------------------------------------------------------------------------
module axis_rate_limit #(
    parameter int DATA_WIDTH = 8,
    parameter int RATE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    axis_rate_limit_if.slave      input_axis,
    axis_rate_limit_if.master     output_axis,
    input  logic [RATE_WIDTH-1:0] rate_num,
    input  logic [RATE_WIDTH-1:0] rate_denom,
    output logic                  pause
);
    localparam int ACC_WIDTH = RATE_WIDTH + 1;

    logic [ACC_WIDTH-1:0]  acc;
    logic [ACC_WIDTH-1:0]  acc_next;
    logic [ACC_WIDTH:0]    sum;       // one bit wider so overflow is visible
    logic                  throttle;
    logic                  accept;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  last_q;
    logic                  user_q;

    assign throttle = (acc >= {1'b0, rate_num});

`ifdef AXIS_RATE_LIMIT_FRAME_EN
    logic frame_active;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_active <= 1'b0;
        end else if (accept) begin
            frame_active <= ~input_axis.tlast;
        end
    end

    // Throttle only between frames; credit keeps accruing inside a frame.
    assign pause = throttle & ~frame_active & rst_n;
`else
    assign pause = throttle & rst_n;
`endif

    assign input_axis.tready = (output_axis.tready | ~valid_q) & ~pause & rst_n;
    assign accept            = input_axis.tvalid & input_axis.tready;

    always_comb begin
        sum = {1'b0, acc};
        if (accept) begin
            sum = sum + {2'b00, rate_denom};
        end
        acc_next = '0;
        if (sum[ACC_WIDTH]) begin
            acc_next = '1;
        end else if (sum > {2'b00, rate_num}) begin
            acc_next = sum[ACC_WIDTH-1:0] - {1'b0, rate_num};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
            data_q  <= input_axis.tdata;
            last_q  <= input_axis.tlast;
            user_q  <= input_axis.tuser;
        end else if (output_axis.tready) begin
            valid_q <= 1'b0;
        end
    end

    assign output_axis.tvalid = valid_q;
    assign output_axis.tdata  = data_q;
    assign output_axis.tlast  = last_q;
    assign output_axis.tuser  = user_q;
endmodule

// File: tb/tb_axis_rate_limit.sv
// ----------------------------------------------------------------------------
// tb_axis_rate_limit
// Directed bench for axis_rate_limit: reset values, several rate ratios,
// backpressure hold, frame-boundary pacing (expectation follows
// AXIS_RATE_LIMIT_FRAME_EN) and asynchronous reset mid-stream.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_axis_rate_limit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rate_num;
    logic [7:0] rate_denom;
    logic       pause;
    int         n_pass  = 0;
    int         n_total = 0;

    axis_rate_limit_if #(.DATA_WIDTH(8)) in_if ();
    axis_rate_limit_if #(.DATA_WIDTH(8)) out_if ();

    axis_rate_limit #(.DATA_WIDTH(8), .RATE_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .input_axis (in_if),
        .output_axis(out_if),
        .rate_num   (rate_num),
        .rate_denom (rate_denom),
        .pause      (pause)
    );

    always #5 clk = ~clk;

    // Leaves the bench 1ns after a rising edge with reset released and idle inputs.
    task automatic do_reset();
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tlast   = 1'b0;
        in_if.tuser   = 1'b0;
        out_if.tready = 1'b1;
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rate_num   = 8'd1;
        rate_denom = 8'd2;
        in_if.tvalid  = 1'b1;
        out_if.tready = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        n_total++;
        if (out_if.tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b expected 0", out_if.tvalid); else n_pass++;
        n_total++;
        if (out_if.tdata !== 8'h00) $display("FAIL reset_tdata: got %h expected 00", out_if.tdata); else n_pass++;
        n_total++;
        if ({out_if.tlast, out_if.tuser} !== 2'b00) $display("FAIL reset_last_user: got %b expected 00", {out_if.tlast, out_if.tuser}); else n_pass++;
        n_total++;
        if (in_if.tready !== 1'b0) $display("FAIL reset_in_tready: got %b expected 0", in_if.tready); else n_pass++;
        n_total++;
        if (pause !== 1'b0) $display("FAIL reset_pause: got %b expected 0", pause); else n_pass++;
        n_total++;
        if (dut.acc !== 9'd0) $display("FAIL reset_acc: got %0d expected 0", dut.acc); else n_pass++;
    endtask

    // 1/2: accept every other cycle, acc alternates 0,1.
    task automatic test_rate_half();
        int accepted = 0;
        do_reset();
        rate_num   = 8'd1;
        rate_denom = 8'd2;
        in_if.tvalid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_if.tdata = 8'(accepted);
            @(negedge clk);
            n_total++;
            if (dut.acc !== 9'(k % 2)) $display("FAIL half_acc[%0d]: got %0d expected %0d", k, dut.acc, k % 2); else n_pass++;
            n_total++;
            if (in_if.tready !== (k % 2 == 0)) $display("FAIL half_tready[%0d]: got %b expected %b", k, in_if.tready, (k % 2 == 0)); else n_pass++;
            if (k % 2 == 1) begin
                n_total++;
                if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'((k - 1) / 2))
                    $display("FAIL half_out[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_if.tvalid, out_if.tdata, 8'((k - 1) / 2));
                else n_pass++;
            end
            if (in_if.tvalid && in_if.tready) accepted++;
            @(posedge clk);
            #1;
        end
        in_if.tvalid = 1'b0;
        n_total++;
        if (accepted !== 10) $display("FAIL half_count: got %0d expected 10", accepted); else n_pass++;
    endtask

    // 2/3: accept, accept, pause; acc 0,1,2.
    task automatic test_rate_two_thirds();
        int accepted = 0;
        do_reset();
        rate_num   = 8'd2;
        rate_denom = 8'd3;
        in_if.tvalid = 1'b1;
        for (int k = 0; k < 30; k++) begin
            in_if.tdata = 8'(accepted);
            @(negedge clk);
            n_total++;
            if (dut.acc !== 9'(k % 3)) $display("FAIL twothirds_acc[%0d]: got %0d expected %0d", k, dut.acc, k % 3); else n_pass++;
            n_total++;
            if (in_if.tready !== (k % 3 != 2)) $display("FAIL twothirds_tready[%0d]: got %b expected %b", k, in_if.tready, (k % 3 != 2)); else n_pass++;
            if (k >= 1 && ((k - 1) % 3) != 2) begin
                n_total++;
                if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'(2 * ((k - 1) / 3) + ((k - 1) % 3)))
                    $display("FAIL twothirds_out[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_if.tvalid, out_if.tdata, 8'(2 * ((k - 1) / 3) + ((k - 1) % 3)));
                else n_pass++;
            end
            if (in_if.tvalid && in_if.tready) accepted++;
            @(posedge clk);
            #1;
        end
        in_if.tvalid = 1'b0;
        n_total++;
        if (accepted !== 20) $display("FAIL twothirds_count: got %0d expected 20", accepted); else n_pass++;
    endtask

    // 5/3: never throttled, 16 words back-to-back with one cycle latency.
    task automatic test_unthrottled();
        int accepted = 0;
        do_reset();
        rate_num   = 8'd5;
        rate_denom = 8'd3;
        for (int k = 0; k < 17; k++) begin
            in_if.tvalid = (k < 16);
            in_if.tdata  = 8'(8'h40 + k);
            @(negedge clk);
            n_total++;
            if (in_if.tready !== 1'b1 || dut.acc !== 9'd0)
                $display("FAIL unthrottled_ready_acc[%0d]: got r=%b acc=%0d expected r=1 acc=0", k, in_if.tready, dut.acc);
            else n_pass++;
            if (k >= 1) begin
                n_total++;
                if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'(8'h40 + k - 1))
                    $display("FAIL unthrottled_out[%0d]: got v=%b d=%h expected v=1 d=%h", k, out_if.tvalid, out_if.tdata, 8'(8'h40 + k - 1));
                else n_pass++;
            end
            if (in_if.tvalid && in_if.tready) accepted++;
            @(posedge clk);
            #1;
        end
        in_if.tvalid = 1'b0;
        n_total++;
        if (accepted !== 16) $display("FAIL unthrottled_count: got %0d expected 16", accepted); else n_pass++;
    endtask

    // 1/1 with a 4-cycle downstream stall while a word is held.
    task automatic test_backpressure();
        do_reset();
        rate_num   = 8'd1;
        rate_denom = 8'd1;
        in_if.tvalid = 1'b1;
        in_if.tdata  = 8'hA5;
        in_if.tlast  = 1'b1;
        in_if.tuser  = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_if.tready !== 1'b1) $display("FAIL bp_first_ready: got %b expected 1", in_if.tready); else n_pass++;
        @(posedge clk);
        #1;
        in_if.tdata   = 8'h3C;
        in_if.tlast   = 1'b0;
        in_if.tuser   = 1'b0;
        out_if.tready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_total++;
            if ({out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser} !== {1'b1, 8'hA5, 1'b1, 1'b1})
                $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b u=%b expected v=1 d=a5 l=1 u=1", k, out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser);
            else n_pass++;
            n_total++;
            if (in_if.tready !== 1'b0) $display("FAIL bp_stall_ready[%0d]: got %b expected 0", k, in_if.tready); else n_pass++;
            @(posedge clk);
            #1;
        end
        out_if.tready = 1'b1;
        @(negedge clk);
        n_total++;
        if (in_if.tready !== 1'b1 || out_if.tdata !== 8'hA5)
            $display("FAIL bp_release: got r=%b d=%h expected r=1 d=a5", in_if.tready, out_if.tdata);
        else n_pass++;
        @(posedge clk);
        #1;
        in_if.tvalid = 1'b0;
        @(negedge clk);
        n_total++;
        if ({out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser} !== {1'b1, 8'h3C, 1'b0, 1'b0})
            $display("FAIL bp_second: got v=%b d=%h l=%b u=%b expected v=1 d=3c l=0 u=0", out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser);
        else n_pass++;
        @(posedge clk);
        #1;
        @(negedge clk);
        n_total++;
        if (out_if.tvalid !== 1'b0) $display("FAIL bp_drain: got %b expected 0", out_if.tvalid); else n_pass++;
    endtask

    // 1/4 with two 4-word frames offered back to back.
    task automatic test_frame();
        int  accepted = 0;
        logic exp_ready;
        do_reset();
        rate_num   = 8'd1;
        rate_denom = 8'd4;
        for (int k = 0; k < 32; k++) begin
            in_if.tvalid = (accepted < 8);
            in_if.tdata  = 8'(accepted);
            in_if.tlast  = (accepted % 4 == 3);
`ifdef AXIS_RATE_LIMIT_FRAME_EN
            exp_ready = (k < 4) || (k >= 16 && k < 20);
`else
            exp_ready = (k % 4 == 0);
`endif
            @(negedge clk);
            n_total++;
            if (in_if.tready !== exp_ready) $display("FAIL frame_tready[%0d]: got %b expected %b", k, in_if.tready, exp_ready); else n_pass++;
            n_total++;
            if (pause !== ~exp_ready) $display("FAIL frame_pause[%0d]: got %b expected %b", k, pause, ~exp_ready); else n_pass++;
            if (in_if.tvalid && in_if.tready) accepted++;
            @(posedge clk);
            #1;
        end
        in_if.tvalid = 1'b0;
        in_if.tlast  = 1'b0;
        n_total++;
        if (accepted !== 8) $display("FAIL frame_count: got %0d expected 8", accepted); else n_pass++;
    endtask

    // Reset pulled mid-cycle while a word is held and credit is outstanding.
    task automatic test_async_reset();
        do_reset();
        rate_num   = 8'd1;
        rate_denom = 8'd3;
        in_if.tvalid = 1'b1;
        in_if.tdata  = 8'h11;
        in_if.tuser  = 1'b1;
        in_if.tlast  = 1'b0;
        @(posedge clk);
        #3;
        n_total++;
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'h11 || dut.acc !== 9'd2)
            $display("FAIL areset_pre: got v=%b d=%h acc=%0d expected v=1 d=11 acc=2", out_if.tvalid, out_if.tdata, dut.acc);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser} !== 11'd0)
            $display("FAIL areset_out: got v=%b d=%h l=%b u=%b expected all 0", out_if.tvalid, out_if.tdata, out_if.tlast, out_if.tuser);
        else n_pass++;
        n_total++;
        if (in_if.tready !== 1'b0 || pause !== 1'b0 || dut.acc !== 9'd0)
            $display("FAIL areset_state: got r=%b p=%b acc=%0d expected r=0 p=0 acc=0", in_if.tready, pause, dut.acc);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        in_if.tdata = 8'h77;
        #1;
        n_total++;
        if (in_if.tready !== 1'b1) $display("FAIL areset_release_ready: got %b expected 1", in_if.tready); else n_pass++;
        @(posedge clk);
        #1;
        in_if.tvalid = 1'b0;
        n_total++;
        if (out_if.tvalid !== 1'b1 || out_if.tdata !== 8'h77 || dut.acc !== 9'd2)
            $display("FAIL areset_first_word: got v=%b d=%h acc=%0d expected v=1 d=77 acc=2", out_if.tvalid, out_if.tdata, dut.acc);
        else n_pass++;
    endtask

    initial begin
        rst_n         = 1'b0;
        rate_num      = '0;
        rate_denom    = '0;
        in_if.tvalid  = 1'b0;
        in_if.tdata   = '0;
        in_if.tlast   = 1'b0;
        in_if.tuser   = 1'b0;
        out_if.tready = 1'b1;
        test_reset();
        test_rate_half();
        test_rate_two_thirds();
        test_unthrottled();
        test_backpressure();
        test_frame();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
